// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared ALUop code set, arbiter FSM state type and small helpers
// used by the alu and alu_arbiter blocks.
package alu_arb_pkg;

  // 3-bit ALUop code set
  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SLTU = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_NOR  = 3'b101;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  // Last-granted requester after reset: 1, so requester 0 is preferred next.
  localparam logic RR_PTR_RESET = 1'b1;

  // Response slot state
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } arb_state_e;

  // Ops that go through the adder and therefore report carry/overflow.
  function automatic logic is_arith(input logic [2:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_SLT) || (op == ALU_SLTU);
  endfunction

  // Ops that use the adder in subtract mode (A + ~B + 1).
  function automatic logic is_subtract(input logic [2:0] op);
    return (op == ALU_SUB) || (op == ALU_SLT) || (op == ALU_SLTU);
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// alu: combinational ALU shared by the arbiter's requesters.
// Arithmetic ops report CarryOut (carry out of the adder; for subtract modes
// 1 means no borrow) and signed Overflow of the adder; logic ops clear both.
// SLT/SLTU report the flags of the underlying A-B subtraction.
module alu
  import alu_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [2:0]            alu_op,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero,
  output logic                  overflow,
  output logic                  carry_out
);

  logic                  sub_mode;
  logic [DATA_WIDTH-1:0] b_eff;
  logic [DATA_WIDTH:0]   sum;
  logic                  add_ovf;
  logic                  slt_bit;
  logic                  sltu_bit;

  // Shared adder: add or subtract depending on op
  always_comb begin
    sub_mode = is_subtract(alu_op);
    b_eff    = sub_mode ? ~b : b;
    sum      = {1'b0, a} + {1'b0, b_eff} + {{DATA_WIDTH{1'b0}}, sub_mode};
    add_ovf  = (a[DATA_WIDTH-1] == b_eff[DATA_WIDTH-1]) &&
               (sum[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
    slt_bit  = sum[DATA_WIDTH-1] ^ add_ovf;
    sltu_bit = ~sum[DATA_WIDTH];
  end

  // Result select and flags
  always_comb begin
    result = '0;
    unique case (alu_op)
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_ADD:  result = sum[DATA_WIDTH-1:0];
      ALU_SLTU: result[0] = sltu_bit;
      ALU_XOR:  result = a ^ b;
      ALU_NOR:  result = ~(a | b);
      ALU_SUB:  result = sum[DATA_WIDTH-1:0];
      ALU_SLT:  result[0] = slt_bit;
      default:  result = '0;
    endcase
    zero      = (result == '0);
    overflow  = is_arith(alu_op) ? add_ovf : 1'b0;
    carry_out = is_arith(alu_op) ? sum[DATA_WIDTH] : 1'b0;
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one alu; the granted request's result is
// captured in a single-entry response slot (EMPTY/FULL) with 1-cycle latency.
// Optional feature macro: ALU_ARB_ROUND_ROBIN_EN (round-robin arbitration;
// without it requester 0 has fixed priority).
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  input  logic [2:0]            req0_op,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  input  logic [2:0]            req1_op,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_zero,
  output logic                  rsp_overflow,
  output logic                  rsp_carryout
);

  arb_state_e            state;
  logic                  grant_id;
  logic                  any_valid;
  logic                  slot_free;
  logic                  accept;
  logic [DATA_WIDTH-1:0] alu_a;
  logic [DATA_WIDTH-1:0] alu_b;
  logic [2:0]            alu_op;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_zero;
  logic                  alu_overflow;
  logic                  alu_carry_out;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic last_id;
`endif

  // Grant selection among valid requesters
  always_comb begin
    any_valid = req0_valid || req1_valid;
`ifdef ALU_ARB_ROUND_ROBIN_EN
    if (req0_valid && req1_valid) grant_id = ~last_id;
    else                          grant_id = req1_valid && !req0_valid;
`else
    grant_id = req1_valid && !req0_valid;
`endif
  end

  // Handshake: accept when the slot is empty or being drained this cycle;
  // rst_n gating keeps both readies low while reset is asserted.
  always_comb begin
    slot_free  = (state == ST_EMPTY) || rsp_ready;
    accept     = rst_n && any_valid && slot_free;
    req0_ready = accept && !grant_id;
    req1_ready = accept && grant_id;
  end

  // Operand mux towards the shared alu
  always_comb begin
    alu_a  = grant_id ? req1_a  : req0_a;
    alu_b  = grant_id ? req1_b  : req0_b;
    alu_op = grant_id ? req1_op : req0_op;
  end

  alu #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_alu (
    .a         (alu_a),
    .b         (alu_b),
    .alu_op    (alu_op),
    .result    (alu_result),
    .zero      (alu_zero),
    .overflow  (alu_overflow),
    .carry_out (alu_carry_out)
  );

  // Response slot FSM with registered response fields and arbitration pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_EMPTY;
      rsp_id       <= 1'b0;
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_carryout <= 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      last_id      <= RR_PTR_RESET;
`endif
    end else begin
      if (accept) begin
        state        <= ST_FULL;
        rsp_id       <= grant_id;
        rsp_result   <= alu_result;
        rsp_zero     <= alu_zero;
        rsp_overflow <= alu_overflow;
        rsp_carryout <= alu_carry_out;
`ifdef ALU_ARB_ROUND_ROBIN_EN
        last_id      <= grant_id;
`endif
      end else if (rsp_ready) begin
        state <= ST_EMPTY;
      end
    end
  end

  assign rsp_valid = (state == ST_FULL);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: table-driven vectors, hand-written corner sequences and a
// randomized phase checked against a behavioural model of the arbiter.
module tb_alu_arbiter;

  localparam int unsigned W = 32;

  localparam logic [2:0] OP_AND = 3'b000, OP_OR = 3'b001, OP_ADD = 3'b010, OP_SLTU = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100, OP_NOR = 3'b101, OP_SUB = 3'b110, OP_SLT = 3'b111;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]   req0_op, req1_op;
  logic         rsp_valid, rsp_ready, rsp_id;
  logic [W-1:0] rsp_result;
  logic         rsp_zero, rsp_overflow, rsp_carryout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(
    .DATA_WIDTH (W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .req0_op      (req0_op),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .req1_op      (req1_op),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_result   (rsp_result),
    .rsp_zero     (rsp_zero),
    .rsp_overflow (rsp_overflow),
    .rsp_carryout (rsp_carryout)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural reference ----------------
  typedef struct {
    logic [W-1:0] r;
    logic         z;
    logic         o;
    logic         c;
  } alu_res_t;

  function automatic bit out_of_range(input longint v);
    return (v > 64'sd2147483647) || (v < -64'sd2147483648);
  endfunction

  function automatic alu_res_t ref_alu(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    alu_res_t res;
    longint   sa = longint'($signed(a));
    longint   sb = longint'($signed(b));
    longint   ua = longint'(a);
    longint   ub = longint'(b);
    longint   s;
    res.r = '0; res.o = 1'b0; res.c = 1'b0;
    case (op)
      OP_AND: res.r = a & b;
      OP_OR:  res.r = a | b;
      OP_XOR: res.r = a ^ b;
      OP_NOR: res.r = ~(a | b);
      OP_ADD: begin
        s     = ua + ub;
        res.r = s[W-1:0];
        res.c = (s > 64'sd4294967295);
        res.o = out_of_range(sa + sb);
      end
      default: begin // SUB, SLT, SLTU: flags of A-B
        s     = ua - ub;
        res.c = (ua >= ub);
        res.o = out_of_range(sa - sb);
        if (op == OP_SUB)      res.r = s[W-1:0];
        else if (op == OP_SLT) res.r = (sa < sb) ? 1 : 0;
        else                   res.r = (ua < ub) ? 1 : 0;
      end
    endcase
    res.z = (res.r == 0);
    return res;
  endfunction

  // Model state: slot contents and last accepted requester
  bit       m_full;
  bit       m_id;
  alu_res_t m_res;
  bit       m_last;

  task automatic model_reset();
    m_full = 0; m_id = 0; m_res.r = '0; m_res.z = 0; m_res.o = 0; m_res.c = 0; m_last = 1;
  endtask

  // Compute expected readies for the current inputs and advance the model
  task automatic model_step(output bit e_r0, output bit e_r1);
    bit win;
    bit acc;
    if (req0_valid && req1_valid) win = RR ? !m_last : 1'b0;
    else                          win = req1_valid;
    acc  = (req0_valid || req1_valid) && (!m_full || rsp_ready);
    e_r0 = acc && !win;
    e_r1 = acc && win;
    if (acc) begin
      m_full = 1; m_id = win; m_last = win;
      m_res  = win ? ref_alu(req1_op, req1_a, req1_b) : ref_alu(req0_op, req0_a, req0_b);
    end else if (rsp_ready) begin
      m_full = 0;
    end
  endtask

  task automatic check_model_outputs();
    chk("rnd_valid", rsp_valid, m_full);
    chk("rnd_id", rsp_id, m_id);
    chk("rnd_result", rsp_result, m_res.r);
    chk("rnd_flags", {rsp_zero, rsp_overflow, rsp_carryout}, {m_res.z, m_res.o, m_res.c});
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    req0_valid = 0; req1_valid = 0;
    req0_a = '0; req0_b = '0; req0_op = OP_AND;
    req1_a = '0; req1_b = '0; req1_op = OP_AND;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; rsp_ready = 0;
    idle();
    req0_valid = 1; req1_valid = 1;
    #1;
    chk("reset_ready0", req0_ready, 1'b0);
    chk("reset_ready1", req1_ready, 1'b0);
    @(negedge clk);
    chk("reset_valid", rsp_valid, 1'b0);
    chk("reset_fields", {rsp_id, rsp_result, rsp_zero, rsp_overflow, rsp_carryout}, '0);
    rst_n = 1;
    idle();
    model_reset();
  endtask

  task automatic drive_one(input bit id, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    idle();
    if (id) begin req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return W'($urandom_range(0, 3));
      default: return $urandom();
    endcase
  endfunction

  typedef struct {
    bit           id;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         z;
    logic         o;
    logic         c;
  } vec_t;

  vec_t tbl[12];

  initial begin
    bit e_r0, e_r1;
    bit exp_id;

    // id  op       a             b             result        z  o  c
    tbl[0]  = '{0, OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0, 1, 0};
    tbl[1]  = '{1, OP_SUB,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1, 0, 1};
    tbl[2]  = '{0, OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 0, 0, 1};
    tbl[3]  = '{0, OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 0, 1};
    tbl[4]  = '{1, OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0, 0, 0};
    tbl[5]  = '{1, OP_OR,   32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 0, 0, 0};
    tbl[6]  = '{0, OP_XOR,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0, 0};
    tbl[7]  = '{1, OP_NOR,  32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 0, 0, 0};
    tbl[8]  = '{0, OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 0, 1};
    tbl[9]  = '{1, OP_SUB,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 0, 0, 0};
    tbl[10] = '{0, OP_SUB,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 0, 1, 1};
    tbl[11] = '{1, OP_SLT,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0, 0};

    rst_n = 0; rsp_ready = 0;
    idle();
    do_reset();

    // Back-to-back accepts with rsp_ready=1: each new accept overwrites the slot
    rsp_ready = 1;
    for (int i = 0; i < 12; i++) begin
      drive_one(tbl[i].id, tbl[i].op, tbl[i].a, tbl[i].b);
      #1;
      chk("vec_ready", {req1_ready, req0_ready}, tbl[i].id ? 2'b10 : 2'b01);
      @(negedge clk);
      chk("vec_valid", rsp_valid, 1'b1);
      chk("vec_id", rsp_id, tbl[i].id);
      chk("vec_result", rsp_result, tbl[i].res);
      chk("vec_flags", {rsp_zero, rsp_overflow, rsp_carryout}, {tbl[i].z, tbl[i].o, tbl[i].c});
    end
    idle();
    @(negedge clk);
    chk("drain_valid", rsp_valid, 1'b0);

    // Stall: SUB 5-5 from requester 1 held while rsp_ready=0
    drive_one(1, OP_SUB, 32'd5, 32'd5);
    #1;
    chk("stall_accept", req1_ready, 1'b1);
    @(negedge clk);
    rsp_ready = 0;
    req0_valid = 1; req0_op = OP_ADD; req0_a = 32'd1; req0_b = 32'd2;
    req1_op = OP_ADD; req1_a = 32'd3; req1_b = 32'd4;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_ready", {req1_ready, req0_ready}, 2'b00);
      @(negedge clk);
      chk("stall_valid", rsp_valid, 1'b1);
      chk("stall_hold", {rsp_id, rsp_result, rsp_zero, rsp_overflow, rsp_carryout},
          {1'b1, 32'h0, 1'b1, 1'b0, 1'b1});
    end
    idle();
    rsp_ready = 1;
    @(negedge clk);
    chk("stall_drain", rsp_valid, 1'b0);

    // Both requesters valid every cycle
    do_reset();
    rsp_ready = 1;
    for (int i = 0; i < 6; i++) begin
      req0_valid = 1; req0_op = OP_ADD; req0_a = W'(i);       req0_b = '0;
      req1_valid = 1; req1_op = OP_ADD; req1_a = W'(100 + i); req1_b = '0;
      exp_id = RR ? bit'(i % 2) : 1'b0;
      #1;
      chk("both_ready", {req1_ready, req0_ready}, exp_id ? 2'b10 : 2'b01);
      @(negedge clk);
      chk("both_id", rsp_id, exp_id);
      chk("both_result", rsp_result, exp_id ? W'(100 + i) : W'(i));
    end
    idle();
    @(negedge clk);

    // Async reset while FULL and stalled
    rsp_ready = 0;
    drive_one(1, OP_OR, 32'h1234_0000, 32'h0000_5678);
    @(negedge clk);
    chk("ar_full", rsp_valid, 1'b1);
    req0_valid = 1;
    #2;
    rst_n = 0;
    #1;
    chk("ar_valid", rsp_valid, 1'b0);
    chk("ar_fields", {rsp_id, rsp_result, rsp_zero, rsp_overflow, rsp_carryout}, '0);
    chk("ar_ready", {req1_ready, req0_ready}, 2'b00);
    @(negedge clk);
    rst_n = 1;
    rsp_ready = 1;
    req0_valid = 1; req0_op = OP_ADD; req0_a = 32'd7; req0_b = 32'd8;
    req1_valid = 1; req1_op = OP_ADD; req1_a = 32'd9; req1_b = 32'd9;
    #1;
    chk("ar_grant", {req1_ready, req0_ready}, 2'b01);
    @(negedge clk);
    chk("ar_rsp", {rsp_valid, rsp_id, rsp_result}, {1'b1, 1'b0, 32'd15});

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      check_model_outputs();
      req0_valid = ($urandom_range(0, 3) != 0);
      req1_valid = ($urandom_range(0, 3) != 0);
      req0_op = 3'($urandom_range(0, 7)); req0_a = pick(); req0_b = pick();
      req1_op = 3'($urandom_range(0, 7)); req1_a = pick(); req1_b = pick();
      rsp_ready = ($urandom_range(0, 2) != 0);
      #1;
      model_step(e_r0, e_r1);
      chk("rnd_ready", {req1_ready, req0_ready}, {e_r1, e_r0});
      @(negedge clk);
    end
    check_model_outputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, 32, operand/result width; SHALL match the width of the shared alu instance.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous and active-low.
REQ-004 req0_valid / req1_valid  input  1 each  requester n presents an operation.
REQ-005 req0_ready / req1_ready  output  1 each  requester n's operation is accepted this cycle.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  DATA_WIDTH each  operands A, B of requester n.
REQ-007 req0_op / req1_op  input  3 each  ALUop of requester n; the 3-bit ALUop code set SHALL be used.
REQ-008 rsp_valid  output  1  response slot holds a result.
REQ-009 rsp_ready  input  1  consumer accepts the response this cycle.
REQ-010 rsp_id  output  1  requester index (0/1) that owns the response.
REQ-011 rsp_result  output  DATA_WIDTH  registered ALU Result.
REQ-012 rsp_zero, rsp_overflow, rsp_carryout  output  1 each  registered ALU Zero/Overflow/CarryOut.

Function
REQ-013 FSM states SHALL be EMPTY (no response held) and FULL (response held).
REQ-014 Accept SHALL occur when the granted reqN_valid=1 and (state EMPTY or (FULL and rsp_ready=1)); reqN_ready SHALL be combinational, 1 only for the granted requester under that condition.
REQ-015 At most one request SHALL be accepted per cycle; the non-granted requester's ready SHALL be 0.
REQ-016 Accepted operands/op SHALL drive the alu combinationally; Result and flags SHALL be registered into the response slot on the accept edge; latency accept -> rsp_valid = 1 cycle.
REQ-017 Transitions: EMPTY+accept -> FULL; FULL+rsp_ready+accept -> FULL (slot overwritten with new result, back-to-back throughput 1/cycle); FULL+rsp_ready+no accept -> EMPTY; FULL+!rsp_ready -> FULL, outputs held stable.
REQ-018 While FULL and rsp_ready=0, all response outputs SHALL remain unchanged and both req ready SHALL be 0.
REQ-019 Arbitration SHALL be evaluated only among requesters with valid=1; a single valid requester SHALL always be granted (subject to REQ-014).
REQ-020 Once reqN_valid is asserted and not accepted, the requester SHALL hold it; the arbiter SHALL not require this but SHALL not starve it (see REQ-025).
REQ-021 Invalid ALUop (none in code set undefined) passes through; rsp fields SHALL be exactly the alu outputs captured.
REQ-022 When the slot is empty rsp_valid SHALL be 0; rsp_result/flags/id SHALL retain last values (don't-care to consumer).

Reset
REQ-023 Asserting rst_n=0 at any time, including mid-handshake, SHALL immediately force state EMPTY, rsp_valid=0, rsp_id=0, rsp_result=0, flags=0, round-robin pointer=1 (requester 0 preferred next); any held response is discarded.
REQ-024 req ready outputs SHALL be 0 while rst_n=0.

Configuration
REQ-025 Macro ALU_ARB_ROUND_ROBIN_EN defined: on a cycle with both valid, the requester not granted last accept SHALL win; the pointer SHALL update only on an accept.
REQ-026 Macro undefined: fixed priority, requester 0 SHALL always win when both valid; the pointer register SHALL not exist.

Structure
REQ-027 Package alu_arb_pkg SHALL hold the ALUop code constants (AND=000, OR=001, ADD=010, SLTU=011, XOR=100, NOR=101, SUB=110, SLT=111) and the FSM state typedef.
REQ-028 The existing alu module SHALL be the single sub-module, instantiated once; grant mux, FSM and response register live in alu_arbiter.

Verification
REQ-029 Reset then req0 ADD A=0x7FFFFFFF B=1, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, result=0x80000000, overflow=1, carryout=0, zero=0.
REQ-030 Both valid every cycle, rsp_ready=1, ROUND_ROBIN_EN defined -> accepts alternate 0,1,0,1, one rsp per cycle; undefined -> only id 0 accepted while req0_valid=1.
REQ-031 req1 SUB A=5 B=5 accepted, rsp_ready=0 for 3 cycles -> rsp held (result=0, zero=1, carryout=1), req ready=0 throughout, then drains on rsp_ready=1.
REQ-032 FULL with rsp_ready=1 and req0 SLT A=0xFFFFFFFF B=1 valid same cycle -> overwrite, next rsp result=1, stays FULL.
REQ-033 rst_n pulled low while FULL and rsp_ready=0 -> rsp_valid=0 immediately (async), first post-reset grant with both valid goes to requester 0.
